// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock datapath.
// Holds the phase encoding, code geometry, the reset code and the HEX display lookup.
package lock_pkg;

   localparam int unsigned LOCK_CODE_LEN = 6;
   localparam int unsigned LOCK_IDX_W    = 3;
   localparam logic [4*LOCK_CODE_LEN-1:0] LOCK_DEFAULT_CODE = 24'h722297;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // Enrollment phase, also shown on the HEX display
   typedef enum logic [1:0] {
      PH_IDLE    = 2'b00,
      PH_ENTER   = 2'b01,
      PH_CONFIRM = 2'b10,
      PH_ERR     = 2'b11
   } phase_e;

   // Active-low 7-segment patterns (gfedcba) used by the lock display
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      case (d)
         4'd0: s = SEG_0;
         4'd1: s = SEG_1;
         4'd2: s = SEG_2;
         4'd3: s = SEG_3;
         4'd4: s = SEG_4;
         4'd5: s = SEG_5;
         4'd6: s = SEG_6;
         4'd7: s = SEG_7;
         4'd8: s = SEG_8;
         4'd9: s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/code_shadow_reg.sv
// Shadow register file holding the code being enrolled.
// Ports: clk, rst (sync, active-high), i_clr (zero all entries), i_we/i_waddr/i_wdata
// (indexed write), i_raddr/o_rdata (combinational indexed read), o_flat (all digits,
// entry 0 in the MS nibble).
module code_shadow_reg
   import lock_pkg::*;
#(
   parameter int unsigned CODE_LEN = LOCK_CODE_LEN,
   parameter int unsigned IDX_W    = LOCK_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [3:0]            i_wdata,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [3:0]            o_rdata,
   output logic [4*CODE_LEN-1:0] o_flat
);

   logic [3:0] r_mem [CODE_LEN];

   // Storage; clear wins over write
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         for (int i = 0; i < CODE_LEN; i++) r_mem[i] <= 4'd0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

   // Flatten with entry 0 as the first (most significant) digit
   always_comb begin
      o_flat = '0;
      for (int i = 0; i < CODE_LEN; i++) o_flat[4*(CODE_LEN-1-i) +: 4] = r_mem[i];
   end

endmodule

// File: rtl/lock_code_enroll.sv
// Code enrollment for the combination lock: key a new code, key it again to confirm,
// commit only on an exact match.
// Ports: clk, rst (sync, active-high), start/abort (pulses), digit_valid/digit (key press),
// code_out (committed code, first digit MS nibble), committed (1-cycle pulse),
// busy (ENTER/CONFIRM), error (ERR), phase (display encoding), count (digits this phase).
module lock_code_enroll
   import lock_pkg::*;
#(
   parameter int unsigned              CODE_LEN     = LOCK_CODE_LEN,
   parameter logic [4*CODE_LEN-1:0]    DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  digit_valid,
   input  logic [3:0]            digit,
   output logic [4*CODE_LEN-1:0] code_out,
   output logic                  committed,
   output logic                  busy,
   output logic                  error,
   output logic [1:0]            phase,
   output logic [2:0]            count
);

   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

   phase_e                r_state;
   phase_e                w_next_state;
   logic [IDX_W-1:0]      r_count;
   logic [IDX_W-1:0]      w_next_count;
   logic                  r_mismatch;
   logic                  w_next_mismatch;
   logic [4*CODE_LEN-1:0] r_code;
   logic                  r_committed;
   logic                  r_busy;
   logic                  r_error;

   logic                  w_commit;
   logic                  w_shadow_we;
   logic                  w_shadow_clr;
   logic [3:0]            w_rdata;
   logic [4*CODE_LEN-1:0] w_flat;
   logic                  w_digit_ok;
   logic                  w_last;
   logic                  w_mis_acc;

   code_shadow_reg #(
      .CODE_LEN (CODE_LEN),
      .IDX_W    (IDX_W)
   ) u_shadow (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_shadow_clr),
      .i_we    (w_shadow_we),
      .i_waddr (r_count),
      .i_wdata (digit),
      .i_raddr (r_count),
      .o_rdata (w_rdata),
      .o_flat  (w_flat)
   );

   assign w_digit_ok = (digit <= BCD_MAX);
   assign w_last     = (r_count == LAST_IDX);
   // Mismatch is accumulated silently and only acted on after the last digit
   assign w_mis_acc  = r_mismatch | (digit != w_rdata);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= PH_IDLE;
         r_count     <= '0;
         r_mismatch  <= 1'b0;
         r_code      <= DEFAULT_CODE;
         r_committed <= 1'b0;
         r_busy      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_count     <= w_next_count;
         r_mismatch  <= w_next_mismatch;
         r_committed <= w_commit;
         r_busy      <= (w_next_state == PH_ENTER) || (w_next_state == PH_CONFIRM);
         r_error     <= (w_next_state == PH_ERR);
         if (w_commit) r_code <= w_flat;
      end
   end

   // Next-state logic; priority abort > start > digit_valid
   always_comb begin
      w_next_state    = r_state;
      w_next_count    = r_count;
      w_next_mismatch = r_mismatch;
      w_commit        = 1'b0;
      w_shadow_we     = 1'b0;
      w_shadow_clr    = 1'b0;

      if (abort) begin
         w_next_state    = PH_IDLE;
         w_next_count    = '0;
         w_next_mismatch = 1'b0;
      end else if (start) begin
         w_next_state    = PH_ENTER;
         w_next_count    = '0;
         w_next_mismatch = 1'b0;
         w_shadow_clr    = 1'b1;
      end else begin
         case (r_state)
            PH_IDLE: ;
            PH_ERR:  ;
            PH_ENTER: begin
               if (digit_valid) begin
                  if (!w_digit_ok) begin
                     w_next_state = PH_ERR;
                     w_next_count = '0;
                  end else begin
                     w_shadow_we = 1'b1;
                     if (w_last) begin
                        w_next_state    = PH_CONFIRM;
                        w_next_count    = '0;
                        w_next_mismatch = 1'b0;
                     end else begin
                        w_next_count = r_count + IDX_W'(1);
                     end
                  end
               end
            end
            PH_CONFIRM: begin
               if (digit_valid) begin
                  if (!w_digit_ok) begin
                     w_next_state = PH_ERR;
                     w_next_count = '0;
                  end else if (w_last) begin
                     w_next_count    = '0;
                     w_next_mismatch = 1'b0;
                     if (w_mis_acc) begin
                        w_next_state = PH_ERR;
                     end else begin
                        w_next_state = PH_IDLE;
                        w_commit     = 1'b1;
                     end
                  end else begin
                     w_next_mismatch = w_mis_acc;
                     w_next_count    = r_count + IDX_W'(1);
                  end
               end
            end
            default: begin
               w_next_state    = PH_IDLE;
               w_next_count    = '0;
               w_next_mismatch = 1'b0;
            end
         endcase
      end
   end

   assign code_out  = r_code;
   assign committed = r_committed;
   assign busy      = r_busy;
   assign error     = r_error;
   assign phase     = r_state;
   assign count     = r_count;

endmodule

// File: tb/tb_lock_code_enroll.sv
module tb_lock_code_enroll;
   import lock_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, abort, digit_valid;
   logic [3:0]  digit;
   logic [23:0] code_out;
   logic        committed, busy, error;
   logic [1:0]  phase;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lock_code_enroll dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .digit_valid (digit_valid),
      .digit       (digit),
      .code_out    (code_out),
      .committed   (committed),
      .busy        (busy),
      .error       (error),
      .phase       (phase),
      .count       (count)
   );

   // Reference model: digits collected as queues, compared whole at the end
   int          m_ph;
   logic [3:0]  m_a[$];
   logic [3:0]  m_b[$];
   logic [23:0] m_code;
   bit          m_com;

   function automatic int m_count();
      if (m_ph == 1) return m_a.size();
      if (m_ph == 2) return m_b.size();
      return 0;
   endfunction

   task automatic model_step(input bit r, input bit s, input bit a, input bit v, input logic [3:0] d);
      bit same;
      m_com = 0;
      if (r) begin
         m_ph = 0; m_a.delete(); m_b.delete(); m_code = 24'h722297;
      end else if (a) begin
         m_ph = 0; m_a.delete(); m_b.delete();
      end else if (s) begin
         m_ph = 1; m_a.delete(); m_b.delete();
      end else if (v) begin
         if (m_ph == 1) begin
            if (d > 9) begin m_ph = 3; m_a.delete(); end
            else begin
               m_a.push_back(d);
               if (m_a.size() == 6) begin m_ph = 2; m_b.delete(); end
            end
         end else if (m_ph == 2) begin
            if (d > 9) m_ph = 3;
            else begin
               m_b.push_back(d);
               if (m_b.size() == 6) begin
                  same = 1;
                  for (int i = 0; i < 6; i++) if (m_a[i] != m_b[i]) same = 0;
                  if (same) begin
                     m_code = 24'h0;
                     for (int i = 0; i < 6; i++) m_code = (m_code << 4) | 24'(m_a[i]);
                     m_com = 1;
                     m_ph  = 0;
                  end else m_ph = 3;
                  m_b.delete();
               end
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, sample 1ns after posedge, advance the model
   task automatic apply(input bit r, input bit s, input bit a, input bit v, input logic [3:0] d);
      @(negedge clk);
      rst = r; start = s; abort = a; digit_valid = v; digit = d;
      @(posedge clk);
      #1;
      model_step(r, s, a, v, d);
   endtask

   task automatic chk_model(input string nm);
      chk({nm, ".phase"}, 32'(phase), 32'(m_ph));
      chk({nm, ".count"}, 32'(count), 32'(m_count()));
      chk({nm, ".committed"}, 32'(committed), 32'(m_com));
      chk({nm, ".busy"}, 32'(busy), 32'((m_ph == 1) || (m_ph == 2)));
      chk({nm, ".error"}, 32'(error), 32'(m_ph == 3));
      chk({nm, ".code"}, 32'(code_out), 32'(m_code));
   endtask

   typedef struct {
      bit          st, ab, dv;
      logic [3:0]  dg;
      logic [1:0]  ph;
      logic [2:0]  cnt;
      bit          com;
      logic [23:0] code;
   } vec_t;

   vec_t tbl[$];

   function automatic void addv(input bit st, input bit ab, input bit dv, input logic [3:0] dg,
                                input logic [1:0] ph, input logic [2:0] cnt, input bit com,
                                input logic [23:0] code);
      vec_t v;
      v.st = st; v.ab = ab; v.dv = dv; v.dg = dg;
      v.ph = ph; v.cnt = cnt; v.com = com; v.code = code;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [3:0] seq1 [6];
      logic [3:0] d;
      bit r, s, a, v;
      bit saw_com;
      seq1 = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd0};

      rst = 1'b0; start = 1'b0; abort = 1'b0; digit_valid = 1'b0; digit = 4'd0;
      m_ph = 0; m_code = 24'h0; m_com = 0;

      // Reset
      apply(1, 0, 0, 0, 0);
      chk("reset.code", 32'(code_out), 32'h722297);
      chk("reset.phase", 32'(phase), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.error", 32'(error), 32'd0);
      chk("reset.committed", 32'(committed), 32'd0);
      chk("reset.count", 32'(count), 32'd0);

      // Vector table: enroll 135790, invalid digit, abort with simultaneous digit
      addv(0, 0, 1, 4'd5, 2'd0, 3'd0, 0, 24'h722297);   // digit alone in IDLE ignored
      addv(1, 0, 0, 4'd0, 2'd1, 3'd0, 0, 24'h722297);
      for (int i = 0; i < 5; i++) addv(0, 0, 1, seq1[i], 2'd1, 3'(i + 1), 0, 24'h722297);
      addv(0, 0, 1, seq1[5], 2'd2, 3'd0, 0, 24'h722297);
      for (int i = 0; i < 5; i++) addv(0, 0, 1, seq1[i], 2'd2, 3'(i + 1), 0, 24'h722297);
      addv(0, 0, 1, seq1[5], 2'd0, 3'd0, 1, 24'h135790);
      addv(0, 0, 0, 4'd0, 2'd0, 3'd0, 0, 24'h135790);
      addv(1, 0, 1, 4'd3, 2'd1, 3'd0, 0, 24'h135790);   // start+digit in IDLE: digit dropped
      addv(0, 0, 1, 4'd4, 2'd1, 3'd1, 0, 24'h135790);
      addv(0, 0, 1, 4'hA, 2'd3, 3'd0, 0, 24'h135790);   // invalid digit
      addv(0, 0, 1, 4'd5, 2'd3, 3'd0, 0, 24'h135790);   // ignored in ERR
      addv(1, 0, 0, 4'd0, 2'd1, 3'd0, 0, 24'h135790);
      addv(0, 0, 1, 4'd1, 2'd1, 3'd1, 0, 24'h135790);
      addv(0, 0, 1, 4'd2, 2'd1, 3'd2, 0, 24'h135790);
      addv(0, 0, 1, 4'd3, 2'd1, 3'd3, 0, 24'h135790);
      addv(0, 1, 1, 4'd7, 2'd0, 3'd0, 0, 24'h135790);   // abort+digit: digit dropped
      addv(0, 0, 0, 4'd0, 2'd0, 3'd0, 0, 24'h135790);

      foreach (tbl[k]) begin
         apply(0, tbl[k].st, tbl[k].ab, tbl[k].dv, tbl[k].dg);
         chk($sformatf("vec%0d.phase", k), 32'(phase), 32'(tbl[k].ph));
         chk($sformatf("vec%0d.count", k), 32'(count), 32'(tbl[k].cnt));
         chk($sformatf("vec%0d.committed", k), 32'(committed), 32'(tbl[k].com));
         chk($sformatf("vec%0d.code", k), 32'(code_out), 32'(tbl[k].code));
         chk($sformatf("vec%0d.busy", k), 32'(busy), 32'((tbl[k].ph == 2'd1) || (tbl[k].ph == 2'd2)));
         chk($sformatf("vec%0d.error", k), 32'(error), 32'(tbl[k].ph == 2'd3));
      end

      // Late mismatch: first digit differs, reported only after the sixth
      saw_com = 0;
      apply(0, 1, 0, 0, 0);
      for (int i = 1; i <= 6; i++) apply(0, 0, 0, 1, 4'(i));
      apply(0, 0, 0, 1, 4'd9);
      if (committed) saw_com = 1;
      chk("late.phase_c1", 32'(phase), 32'd2);
      for (int i = 2; i <= 5; i++) begin
         apply(0, 0, 0, 1, 4'(i));
         if (committed) saw_com = 1;
         chk($sformatf("late.phase_c%0d", i), 32'(phase), 32'd2);
         chk($sformatf("late.count_c%0d", i), 32'(count), 32'(i));
      end
      apply(0, 0, 0, 1, 4'd6);
      if (committed) saw_com = 1;
      chk("late.phase_err", 32'(phase), 32'd3);
      chk("late.error", 32'(error), 32'd1);
      chk("late.code", 32'(code_out), 32'h135790);
      chk("late.no_commit", 32'(saw_com), 32'd0);
      apply(0, 0, 1, 0, 0);
      chk_model("late.abort_err");

      // Abort mid-confirm
      saw_com = 0;
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         apply(0, 0, 0, 1, 4'd1);
         if (committed) saw_com = 1;
      end
      chk("abortc.phase_pre", 32'(phase), 32'd2);
      chk("abortc.count_pre", 32'(count), 32'd3);
      apply(0, 0, 1, 0, 0);
      if (committed) saw_com = 1;
      chk("abortc.phase", 32'(phase), 32'd0);
      chk("abortc.code", 32'(code_out), 32'h135790);
      chk("abortc.no_commit", 32'(saw_com), 32'd0);

      // Start in CONFIRM restarts entry, then commit 246802, then reset mid-confirm
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) apply(0, 0, 0, 1, 4'd3);
      apply(0, 1, 0, 0, 0);
      chk("restart.phase", 32'(phase), 32'd1);
      chk("restart.count", 32'(count), 32'd0);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 6; i++) apply(0, 0, 0, 1, 4'((2 * i + 2) % 10));
      chk("commit2.code", 32'(code_out), 32'h246802);
      chk("commit2.committed", 32'(committed), 32'd1);
      apply(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) apply(0, 0, 0, 1, 4'd5);
      chk("rstmid.phase_pre", 32'(phase), 32'd2);
      apply(1, 0, 0, 0, 0);
      chk("rstmid.code", 32'(code_out), 32'h722297);
      chk("rstmid.phase", 32'(phase), 32'd0);
      chk("rstmid.count", 32'(count), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 199) == 0);
         a = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 19) == 0) d = 4'($urandom_range(10, 15));
         else if (m_ph == 2 && $urandom_range(0, 9) < 9) d = m_a[m_b.size()];
         else d = 4'($urandom_range(0, 9));
         if (m_ph == 0 && $urandom_range(0, 7) == 0) s = 1;
         apply(r, s, a, v, d);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
